dmem_lsu_port: RTL and testbench
================================

Name: dmem_lsu_port

Overview:
- Initiator side of the data-memory handshake (dmem_read/dmem_write/dmem_addr/dmem_data/dmem_rd_data/dmem_done) that basic_dmem_model responds to.
- Sits between the load/store unit and data memory.
- Accepts one tagged load/store at a time and issues word-aligned requests.
- Sub-word stores are done as read-modify-write; loads are sign- or zero-extended.
- Returns a tagged response with an error code for misalignment or timeout.

Parameters:
- TAG_W, 4, width of the request/response tag.
- TIMEOUT, 64, maximum cycles an asserted dmem request may wait for dmem_done_i before aborting; 0 disables the timeout.

Ports:
- clk_i  in  1  clock.
- reset_ni  in  1  asynchronous, active-low reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted when valid&&ready at posedge.
- req_op_i  in  mem_op_t  LB, LH, LW, LBU, LHU, SB, SH, SW.
- req_addr_i  in  32  byte address.
- req_data_i  in  32  store data, right-justified.
- req_tag_i  in  TAG_W  request tag.
- resp_valid_o  out  1  response valid.
- resp_ready_i  in  1  response consumed when valid&&ready at posedge.
- resp_tag_o  out  TAG_W  tag of the request being answered.
- resp_data_o  out  32  load result; 0 for stores and errors.
- resp_err_o  out  dmem_err_t  OK=0, MISALIGN=1, TIMEOUT=2.
- dmem_read_o  out  1  read request, level.
- dmem_write_o  out  1  write request, level.
- dmem_addr_o  out  32  word address, bits [1:0] = 0.
- dmem_data_o  out  32  write data.
- dmem_rd_data_i  in  32  read data, valid with dmem_done_i.
- dmem_done_i  in  1  one-cycle completion pulse.

Behaviour:
- Reset (async, reset_ni=0):
  - State is IDLE.
  - All outputs are 0, except req_ready_o, which is 1 once reset_ni=1.
  - Reset mid-transaction aborts it; no response is produced.
- Single outstanding request: req_ready_o=1 only in IDLE.
- On acceptance, op, addr, data and tag are registered.
- Misalignment: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, go directly to RESP with MISALIGN. No dmem access is made.
- FSM:
  - IDLE -> RD for a load, SB or SH.
  - IDLE -> WR for SW.
  - IDLE -> RESP for a misaligned request.
  - RD: dmem_read_o=1 and dmem_addr_o held stable.
    - On dmem_done_i for a load: capture the extracted/extended data, go to RESP.
    - On dmem_done_i for SB/SH: capture dmem_rd_data_i, go to MRG.
  - MRG: one cycle with no request asserted. The merged word is registered (byte/half lanes replaced per addr[1:0]/addr[1]). Go to WR.
  - WR: dmem_write_o=1, dmem_data_o=merged word (SW: req data), addr stable. On dmem_done_i go to RESP.
  - RESP: resp_valid_o=1, outputs stable until resp_ready_i. Then go to IDLE; req_ready_o=1 the next cycle.
- Request lines:
  - dmem_read_o and dmem_write_o are never both 1.
  - Each drops the cycle after dmem_done_i.
  - At least one idle cycle separates consecutive dmem operations.
- Timing with memory latency L (done in the L-th cycle of the asserted request):
  - LW accepted at edge t: read asserted from t+1, resp_valid_o from t+L+1.
  - SB: adds L+1 cycles (MRG plus write).
- Timeout:
  - The counter clears on entry to RD/WR and counts each cycle without done.
  - If TIMEOUT>0 and the count reaches TIMEOUT, the request drops and the FSM goes to RESP with TIMEOUT and data 0.
  - On a sub-word store timeout the write is not issued.
- dmem_done_i outside RD/WR is ignored.
- Load extension:
  - LB/LH sign-extend from bit 7/15 of the selected lane.
  - LBU/LHU zero-extend.
  - LW passes the word through.

Decomposition:
- data_types package additions:
  - mem_op_t enum (3 bits).
  - dmem_err_t enum (2 bits).
  - dmem_state_t enum (IDLE, RD, MRG, WR, RESP).
  - Function is_store(mem_op_t).
- Sub-module dmem_lane_align (combinational), containing:
  - Load lane extract/extend.
  - Store merge: inputs op, addr[1:0], word, store data.
  - Misalign detect.
- The top module holds the FSM, the registers and the timeout counter.

Test Plan:
- Reset then SW addr 0x10 data 0xDEADBEEF, then LW 0x10, against basic_dmem_model LATENCY=3 -> write asserted 3 cycles; LW resp_data=0xDEADBEEF, tag echoed, err OK, resp_valid 4 cycles after accept.
- Word 0x11223344 at 0x20; SB 0xAA at 0x22, then LW 0x20 -> RD, MRG, WR sequence with one-cycle gap; LW returns 0x11AA3344.
- Word 0x80FF7F01 at 0x30; LB 0x33 -> 0xFFFFFF80; LBU 0x33 -> 0x00000080; LH 0x30 -> 0x00007F01; LHU 0x32 -> 0x000080FF.
- LW addr 0x41, tag 5 -> resp_err MISALIGN, data 0, no dmem_read_o/dmem_write_o pulse.
- TIMEOUT=8, dmem_done_i tied 0, LW -> dmem_read_o high exactly 8 cycles; then resp_err TIMEOUT.
- Hold resp_ready_i=0 for 5 cycles -> response fields stable, req_ready_o=0.
- Reset_ni pulse mid-RD -> all outputs 0 asynchronously; no response; next LW completes normally.

Source files
------------

// File: rtl/dmem_lsu_port_pkg.sv
// Shared types for the data-memory load/store port: operations, error codes,
// controller states and a store classifier.
package dmem_lsu_port_pkg;

   typedef enum logic [2:0] {
      OP_LB  = 3'd0,
      OP_LH  = 3'd1,
      OP_LW  = 3'd2,
      OP_LBU = 3'd3,
      OP_LHU = 3'd4,
      OP_SB  = 3'd5,
      OP_SH  = 3'd6,
      OP_SW  = 3'd7
   } mem_op_t;

   typedef enum logic [1:0] {
      ERR_OK       = 2'd0,
      ERR_MISALIGN = 2'd1,
      ERR_TIMEOUT  = 2'd2
   } dmem_err_t;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RD   = 3'd1,
      ST_MRG  = 3'd2,
      ST_WR   = 3'd3,
      ST_RESP = 3'd4
   } dmem_state_t;

   function automatic logic is_store(input mem_op_t op);
      return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
   endfunction

endpackage

// File: rtl/dmem_lsu_port_lane_align.sv
// Byte/half lane handling for the load/store port: load extract and extend,
// sub-word store merge into a full word, and alignment check.
module dmem_lane_align
   import dmem_lsu_port_pkg::*;
(
   input  mem_op_t     op,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] word,
   input  logic [31:0] store_data,
   output logic [31:0] load_data,
   output logic [31:0] merged,
   output logic        misalign
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   always_comb begin
      byte_lane = word[7:0];
      case (addr_lo)
         2'd1:    byte_lane = word[15:8];
         2'd2:    byte_lane = word[23:16];
         2'd3:    byte_lane = word[31:24];
         default: byte_lane = word[7:0];
      endcase
      half_lane = addr_lo[1] ? word[31:16] : word[15:0];

      load_data = '0;
      case (op)
         OP_LB:   load_data = {{24{byte_lane[7]}}, byte_lane};
         OP_LBU:  load_data = {24'h0, byte_lane};
         OP_LH:   load_data = {{16{half_lane[15]}}, half_lane};
         OP_LHU:  load_data = {16'h0, half_lane};
         OP_LW:   load_data = word;
         default: load_data = '0;
      endcase

      merged = store_data;
      if (op == OP_SB) begin
         merged = word;
         case (addr_lo)
            2'd0:    merged[7:0]   = store_data[7:0];
            2'd1:    merged[15:8]  = store_data[7:0];
            2'd2:    merged[23:16] = store_data[7:0];
            default: merged[31:24] = store_data[7:0];
         endcase
      end else if (op == OP_SH) begin
         merged = word;
         if (addr_lo[1]) merged[31:16] = store_data[15:0];
         else            merged[15:0]  = store_data[15:0];
      end

      misalign = 1'b0;
      case (op)
         OP_LH, OP_LHU, OP_SH: misalign = addr_lo[0];
         OP_LW, OP_SW:         misalign = (addr_lo != 2'd0);
         default:              misalign = 1'b0;
      endcase
   end

endmodule

// File: rtl/dmem_lsu_port.sv
// Single-outstanding load/store initiator for the data-memory handshake, with
// read-modify-write for sub-word stores and a per-request timeout.
//
// state   | meaning
// IDLE    | ready for a new request
// RD      | word read in flight (loads and the read half of SB/SH)
// MRG     | one quiet cycle while the merged store word is registered
// WR      | word write in flight
// RESP    | response held until the consumer takes it
module dmem_lsu_port
   import dmem_lsu_port_pkg::*;
#(
   parameter int unsigned TAG_W   = 4,
   parameter int unsigned TIMEOUT = 64
)(
   input  logic             clk_i,
   input  logic             reset_ni,
   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  mem_op_t          req_op_i,
   input  logic [31:0]      req_addr_i,
   input  logic [31:0]      req_data_i,
   input  logic [TAG_W-1:0] req_tag_i,
   output logic             resp_valid_o,
   input  logic             resp_ready_i,
   output logic [TAG_W-1:0] resp_tag_o,
   output logic [31:0]      resp_data_o,
   output dmem_err_t        resp_err_o,
   output logic             dmem_read_o,
   output logic             dmem_write_o,
   output logic [31:0]      dmem_addr_o,
   output logic [31:0]      dmem_data_o,
   input  logic [31:0]      dmem_rd_data_i,
   input  logic             dmem_done_i
);

   localparam int unsigned      CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] TMO_LOAD = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

   dmem_state_t      state, state_nxt;
   mem_op_t          op;
   logic [31:0]      addr, store_data, wdata, rdata;
   logic [TAG_W-1:0] tag;
   dmem_err_t        err;
   logic [CNT_W-1:0] tmo_cnt;

   mem_op_t     lane_op;
   logic [1:0]  lane_addr;
   logic [31:0] lane_word, load_data, merged;
   logic        misalign, busy, tmo_hit;

   // In IDLE the lane logic looks at the incoming request so misalignment is
   // known at acceptance; afterwards it works on the registered request.
   assign lane_op   = (state == ST_IDLE) ? req_op_i : op;
   assign lane_addr = (state == ST_IDLE) ? req_addr_i[1:0] : addr[1:0];
   assign lane_word = (state == ST_MRG) ? wdata : dmem_rd_data_i;

   dmem_lane_align u_lane_align (
      .op         (lane_op),
      .addr_lo    (lane_addr),
      .word       (lane_word),
      .store_data (store_data),
      .load_data  (load_data),
      .merged     (merged),
      .misalign   (misalign)
   );

   assign busy    = (state == ST_RD) || (state == ST_WR);
   assign tmo_hit = (TIMEOUT != 0) && busy && !dmem_done_i && (tmo_cnt == '0);

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) state <= ST_IDLE;
      else           state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      req_ready_o  = 1'b0;
      resp_valid_o = 1'b0;
      dmem_read_o  = 1'b0;
      dmem_write_o = 1'b0;
      case (state)
         ST_IDLE: begin
            req_ready_o = reset_ni;
            if (req_valid_i) begin
               if (misalign)                state_nxt = ST_RESP;
               else if (req_op_i == OP_SW)  state_nxt = ST_WR;
               else                         state_nxt = ST_RD;
            end
         end
         ST_RD: begin
            dmem_read_o = 1'b1;
            if (dmem_done_i)  state_nxt = is_store(op) ? ST_MRG : ST_RESP;
            else if (tmo_hit) state_nxt = ST_RESP;
         end
         ST_MRG: state_nxt = ST_WR;
         ST_WR: begin
            dmem_write_o = 1'b1;
            if (dmem_done_i || tmo_hit) state_nxt = ST_RESP;
         end
         ST_RESP: begin
            resp_valid_o = 1'b1;
            if (resp_ready_i) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         op         <= OP_LB;
         addr       <= '0;
         store_data <= '0;
         wdata      <= '0;
         rdata      <= '0;
         tag        <= '0;
         err        <= ERR_OK;
         tmo_cnt    <= '0;
      end else begin
         case (state)
            ST_IDLE: if (req_valid_i) begin
               op         <= req_op_i;
               addr       <= req_addr_i;
               store_data <= req_data_i;
               wdata      <= req_data_i;
               tag        <= req_tag_i;
               rdata      <= '0;
               err        <= misalign ? ERR_MISALIGN : ERR_OK;
               tmo_cnt    <= TMO_LOAD;
            end
            ST_RD, ST_WR: begin
               if (dmem_done_i) begin
                  if (state == ST_RD) begin
                     if (is_store(op)) wdata <= dmem_rd_data_i;
                     else              rdata <= load_data;
                  end
               end else if (tmo_hit) begin
                  err <= ERR_TIMEOUT;
               end else if (TIMEOUT != 0) begin
                  tmo_cnt <= tmo_cnt - CNT_W'(1);
               end
            end
            ST_MRG: begin
               wdata   <= merged;
               tmo_cnt <= TMO_LOAD;
            end
            default: ;
         endcase
      end
   end

   assign dmem_addr_o = {addr[31:2], 2'b00};
   assign dmem_data_o = wdata;
   assign resp_tag_o  = tag;
   assign resp_data_o = rdata;
   assign resp_err_o  = err;

endmodule

// File: tb/tb_dmem_lsu_port.sv
// Randomized bench for dmem_lsu_port: a latency-programmable word memory on the
// dmem side and a byte-addressed reference model for expected responses.
`timescale 1ns/1ps
module tb_dmem_lsu_port;
   import dmem_lsu_port_pkg::*;

   localparam int TAG_W = 4;
   localparam int TMO   = 8;

   logic             clk_sys = 1'b0;
   logic             rst_b = 1'b0;
   logic             req_valid = 1'b0;
   logic             req_ready;
   mem_op_t          req_op = OP_LW;
   logic [31:0]      req_addr = '0;
   logic [31:0]      req_data = '0;
   logic [TAG_W-1:0] req_tag = '0;
   logic             resp_valid;
   logic             resp_ready = 1'b0;
   logic [TAG_W-1:0] resp_tag;
   logic [31:0]      resp_data;
   dmem_err_t        resp_err;
   logic             dmem_read, dmem_write;
   logic [31:0]      dmem_addr, dmem_data, dmem_rd_data;
   logic             dmem_done;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk_sys = ~clk_sys;

   dmem_lsu_port #(.TAG_W(TAG_W), .TIMEOUT(TMO)) dut (
      .clk_i(clk_sys), .reset_ni(rst_b),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
      .req_addr_i(req_addr), .req_data_i(req_data), .req_tag_i(req_tag),
      .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_tag_o(resp_tag),
      .resp_data_o(resp_data), .resp_err_o(resp_err),
      .dmem_read_o(dmem_read), .dmem_write_o(dmem_write), .dmem_addr_o(dmem_addr),
      .dmem_data_o(dmem_data), .dmem_rd_data_i(dmem_rd_data), .dmem_done_i(dmem_done)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", name, got, exp);
      end
   endtask

   // dmem responder: done in the lat-th cycle of an asserted request
   logic [31:0] mem_w [0:63];
   int unsigned lat = 3;
   int unsigned mcnt = 0;
   bit          done_en = 1'b1;
   bit          spur = 1'b0;
   bit          spur_en = 1'b0;
   bit          loaded = 1'b0;
   logic        mem_done;

   function automatic logic [31:0] init_word(input int w);
      return (32'(w) * 32'h9E3779B9) ^ 32'h5A5A1234;
   endfunction

   assign mem_done     = done_en && (dmem_read || dmem_write) && (mcnt == lat - 1);
   assign dmem_done    = mem_done || spur;
   assign dmem_rd_data = mem_w[dmem_addr[7:2]];

   always @(posedge clk_sys) begin
      if (!loaded) begin
         for (int w = 0; w < 64; w++) mem_w[w] <= init_word(w);
         loaded <= 1'b1;
      end else if (mem_done && dmem_write) begin
         mem_w[dmem_addr[7:2]] <= dmem_data;
      end
      if ((dmem_read || dmem_write) && !mem_done) mcnt <= mcnt + 1;
      else                                        mcnt <= 0;
   end

   // stray completion pulses, only while no request is asserted
   always @(negedge clk_sys)
      spur = spur_en && !dmem_read && !dmem_write && ($urandom_range(0, 3) == 0);

   int          rd_cyc = 0, wr_cyc = 0, proto_err = 0;
   logic [31:0] exp_waddr = '0;
   bit          prev_done = 1'b0;

   always @(negedge clk_sys) begin
      if (dmem_read)  rd_cyc++;
      if (dmem_write) wr_cyc++;
      if (dmem_read && dmem_write) proto_err++;
      if (prev_done && (dmem_read || dmem_write)) proto_err++;
      if ((dmem_read || dmem_write) && dmem_addr !== exp_waddr) proto_err++;
      prev_done = (dmem_read || dmem_write) && mem_done;
   end

   // Byte-addressed reference memory
   logic [7:0] ref_b [0:255];

   task automatic model(input mem_op_t op, input logic [31:0] a, input logic [31:0] d,
                        input bit commit, output logic [31:0] rdat, output dmem_err_t e);
      int size;
      logic [31:0] v;
      size = (op == OP_LB || op == OP_LBU || op == OP_SB) ? 1 :
             (op == OP_LH || op == OP_LHU || op == OP_SH) ? 2 : 4;
      rdat = '0;
      if ((int'(a[7:0]) % size) != 0) begin
         e = ERR_MISALIGN;
      end else if (!commit) begin
         e = ERR_TIMEOUT;
      end else begin
         e = ERR_OK;
         if (is_store(op)) begin
            for (int i = 0; i < size; i++) ref_b[int'(a[7:0]) + i] = 8'(d >> (8 * i));
         end else begin
            v = '0;
            for (int i = 0; i < size; i++) v = v | (32'(ref_b[int'(a[7:0]) + i]) << (8 * i));
            if ((op == OP_LB || op == OP_LH) && v[8 * size - 1])
               v = v | (32'hFFFF_FFFF << (8 * size));
            rdat = v;
         end
      end
   endtask

   // Called on a negedge with the DUT idle; returns on a negedge with it idle again.
   task automatic do_req(input mem_op_t op, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] t, input int hold, output logic [31:0] got);
      logic [31:0] e_data;
      dmem_err_t   e_err;
      int e_lat, e_rd, e_wr, rd0, wr0, n;
      model(op, a, d, done_en, e_data, e_err);
      if (e_err == ERR_MISALIGN) begin
         e_lat = 1; e_rd = 0; e_wr = 0;
      end else if (e_err == ERR_TIMEOUT) begin
         e_lat = TMO + 1;
         e_rd  = (op == OP_SW) ? 0 : TMO;
         e_wr  = (op == OP_SW) ? TMO : 0;
      end else if (op == OP_SB || op == OP_SH) begin
         e_lat = 2 * int'(lat) + 2; e_rd = int'(lat); e_wr = int'(lat);
      end else if (op == OP_SW) begin
         e_lat = int'(lat) + 1; e_rd = 0; e_wr = int'(lat);
      end else begin
         e_lat = int'(lat) + 1; e_rd = int'(lat); e_wr = 0;
      end
      exp_waddr = {a[31:2], 2'b00};
      req_valid = 1'b1; req_op = op; req_addr = a; req_data = d; req_tag = t;
      n = 0;
      while (!req_ready && n < 20) begin @(negedge clk_sys); n++; end
      check("req_ready", 32'(req_ready), 32'd1);
      rd0 = rd_cyc; wr0 = wr_cyc;
      @(negedge clk_sys);
      req_valid = 1'b0;
      n = 1;
      while (!resp_valid && n < 200) begin @(negedge clk_sys); n++; end
      check("resp_latency", 32'(n), 32'(e_lat));
      got = resp_data;
      check("resp_tag", 32'(resp_tag), 32'(t));
      check("resp_data", resp_data, e_data);
      check("resp_err", 32'(resp_err), 32'(e_err));
      check("busy_not_ready", 32'(req_ready), 32'd0);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk_sys);
         check("hold_valid", 32'(resp_valid), 32'd1);
         check("hold_tag", 32'(resp_tag), 32'(t));
         check("hold_data", resp_data, e_data);
         check("hold_err", 32'(resp_err), 32'(e_err));
         check("hold_not_ready", 32'(req_ready), 32'd0);
      end
      resp_ready = 1'b1;
      @(negedge clk_sys);
      resp_ready = 1'b0;
      check("ready_after_resp", 32'(req_ready), 32'd1);
      check("valid_after_resp", 32'(resp_valid), 32'd0);
      check("read_cycles", 32'(rd_cyc - rd0), 32'(e_rd));
      check("write_cycles", 32'(wr_cyc - wr0), 32'(e_wr));
   endtask

   initial begin
      logic [31:0] got;
      mem_op_t     rop;
      logic [31:0] ra;
      for (int w = 0; w < 64; w++)
         for (int b = 0; b < 4; b++) ref_b[4 * w + b] = 8'(init_word(w) >> (8 * b));

      repeat (3) @(negedge clk_sys);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_dmem_read", 32'(dmem_read), 32'd0);
      rst_b = 1'b1;
      @(negedge clk_sys);
      check("post_rst_ready", 32'(req_ready), 32'd1);
      check("post_rst_data", resp_data, 32'd0);
      check("post_rst_addr", dmem_addr, 32'd0);
      check("post_rst_err", 32'(resp_err), 32'd0);

      do_req(OP_SW, 32'h10, 32'hDEADBEEF, 4'd1, 0, got);
      do_req(OP_LW, 32'h10, 32'h0, 4'd2, 0, got);
      check("plan_lw", got, 32'hDEADBEEF);

      do_req(OP_SW, 32'h20, 32'h11223344, 4'd3, 0, got);
      do_req(OP_SB, 32'h22, 32'h000000AA, 4'd4, 0, got);
      do_req(OP_LW, 32'h20, 32'h0, 4'd6, 0, got);
      check("plan_sb_merge", got, 32'h11AA3344);

      do_req(OP_SW, 32'h30, 32'h80FF7F01, 4'd7, 0, got);
      do_req(OP_LB, 32'h33, 32'h0, 4'd8, 0, got);
      check("plan_lb", got, 32'hFFFFFF80);
      do_req(OP_LBU, 32'h33, 32'h0, 4'd9, 0, got);
      check("plan_lbu", got, 32'h00000080);
      do_req(OP_LH, 32'h30, 32'h0, 4'd10, 0, got);
      check("plan_lh", got, 32'h00007F01);
      do_req(OP_LHU, 32'h32, 32'h0, 4'd11, 5, got);
      check("plan_lhu", got, 32'h000080FF);

      do_req(OP_LW, 32'h41, 32'h0, 4'd5, 0, got);
      check("plan_misalign_data", got, 32'h0);

      done_en = 1'b0;
      do_req(OP_LW, 32'h44, 32'h0, 4'd12, 0, got);
      do_req(OP_SB, 32'h45, 32'h55, 4'd13, 1, got);
      done_en = 1'b1;
      do_req(OP_LW, 32'h44, 32'h0, 4'd14, 0, got);

      // asynchronous reset in the middle of a read
      exp_waddr = 32'h10;
      req_valid = 1'b1; req_op = OP_LW; req_addr = 32'h10; req_tag = 4'd3;
      @(negedge clk_sys);
      req_valid = 1'b0;
      @(negedge clk_sys);
      check("pre_abort_read", 32'(dmem_read), 32'd1);
      #2 rst_b = 1'b0;
      #1;
      check("abort_read", 32'(dmem_read), 32'd0);
      check("abort_write", 32'(dmem_write), 32'd0);
      check("abort_ready", 32'(req_ready), 32'd0);
      check("abort_valid", 32'(resp_valid), 32'd0);
      check("abort_addr", dmem_addr, 32'd0);
      check("abort_tag", 32'(resp_tag), 32'd0);
      @(negedge clk_sys);
      rst_b = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_sys);
         check("no_resp_after_abort", 32'(resp_valid), 32'd0);
      end
      do_req(OP_LW, 32'h10, 32'h0, 4'd15, 0, got);
      check("lw_after_abort", got, 32'hDEADBEEF);

      spur_en = 1'b1;
      for (int k = 0; k < 80; k++) begin
         lat = $urandom_range(1, 4);
         rop = mem_op_t'($urandom_range(0, 7));
         ra  = 32'($urandom_range(0, 255));
         if ($urandom_range(0, 3) != 0) begin
            if (rop == OP_LW || rop == OP_SW) ra[1:0] = 2'b00;
            else if (rop == OP_LH || rop == OP_LHU || rop == OP_SH) ra[0] = 1'b0;
         end
         do_req(rop, ra, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2), got);
      end
      spur_en = 1'b0;

      check("protocol_violations", 32'(proto_err), 32'd0);
      for (int w = 0; w < 64; w++)
         check("final_mem", mem_w[w],
               {ref_b[4 * w + 3], ref_b[4 * w + 2], ref_b[4 * w + 1], ref_b[4 * w]});

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
